// File: rtl/cdr_loop_filter.sv
// cdr_loop_filter
// Digital loop filter for the receive CDR. Collects early/late votes from the
// bang-bang phase detector in windows of DECIM valid votes, takes the sign of
// each window as a decision, and runs a proportional-plus-integral loop that
// produces a registered, modulo-wrapping phase code for the interpolator.
// Optional feature macro: CDR_INT_PATH_EN (integrator, Sat and integral step
// term). When it is undefined the loop is first order and Int_Out/Sat are 0.
module cdr_loop_filter #(
    parameter int CODE_W     = 11,
    parameter int DECIM      = 8,
    parameter int KP         = 4,
    parameter int KI_SHIFT   = 4,
    parameter int INT_W      = 16,
    parameter int RESET_CODE = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Up,
    input  logic              Dn,
    input  logic              Vote_Valid,
    input  logic              Freeze,
    output logic [CODE_W-1:0] Code,
    output logic              Code_Update,
    output logic [INT_W-1:0]  Int_Out,
    output logic              Sat
);

    localparam int CNT_W  = $clog2(DECIM);
    // Net sum spans [-DECIM, DECIM]; two extra bits cover sign and magnitude.
    localparam int NET_W  = $clog2(DECIM) + 2;
    // Proportional plus integral term is formed one bit wider than the integrator.
    localparam int STEP_W = INT_W + 1;

    localparam logic [CNT_W-1:0]         LAST_CNT = CNT_W'(DECIM - 1);
    localparam logic signed [STEP_W-1:0] KP_STEP  = STEP_W'(KP);

    // Map one phase-detector vote to +1 / 0 / -1.
    function automatic logic signed [1:0] vote_of(input logic up, input logic dn);
        if (up && !dn) begin
            return 2'b01;
        end else if (dn && !up) begin
            return 2'b11;
        end
        return 2'b00;
    endfunction

    // Sign of the window sum as the loop decision.
    function automatic logic signed [1:0] sign_of(input logic signed [NET_W-1:0] v);
        if (v == '0) begin
            return 2'b00;
        end else if (v[NET_W-1]) begin
            return 2'b11;
        end
        return 2'b01;
    endfunction

    logic [CNT_W-1:0]         r_count;
    logic signed [NET_W-1:0]  r_net;
    logic signed [1:0]        r_dec;
    logic                     r_dec_vld;
    logic [CODE_W-1:0]        r_code;
    logic                     r_upd;

    logic signed [1:0]        w_vote;
    logic signed [NET_W-1:0]  w_vote_ext;
    logic signed [NET_W-1:0]  w_net_sum;
    logic                     w_last;
    logic                     w_decide;
    logic                     w_update;
    logic signed [STEP_W-1:0] w_prop;
    logic signed [STEP_W-1:0] w_int_term;
    logic signed [STEP_W-1:0] w_step;
    logic [CODE_W-1:0]        w_step_code;

    assign w_vote     = vote_of(Up, Dn);
    assign w_vote_ext = {{(NET_W-2){w_vote[1]}}, w_vote};
    assign w_net_sum  = r_net + w_vote_ext;
    assign w_last     = (r_count == LAST_CNT);
    // Freeze overrides a decision-cycle vote.
    assign w_decide   = Vote_Valid && w_last && !Freeze;
    // A pending decision is discarded if Freeze is high when it would apply.
    assign w_update   = r_dec_vld && !Freeze;

    // Vote window: count valid votes and accumulate their net sum.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count <= '0;
            r_net   <= '0;
        end else if (Freeze) begin
            r_count <= '0;
            r_net   <= '0;
        end else if (Vote_Valid) begin
            if (w_last) begin
                r_count <= '0;
                r_net   <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
                r_net   <= w_net_sum;
            end
        end
    end

    // Register the window decision for the update on the following edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_dec_vld <= 1'b0;
            r_dec     <= 2'b00;
        end else begin
            r_dec_vld <= w_decide;
            if (w_decide) begin
                r_dec <= sign_of(w_net_sum);
            end
        end
    end

`ifdef CDR_INT_PATH_EN
    localparam logic signed [INT_W-1:0] INT_POS = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_NEG = {1'b1, {(INT_W-2){1'b0}}, 1'b1};

    // Integrator step by +/-1 with symmetric clamping at +/-(2^(INT_W-1)-1).
    function automatic logic signed [INT_W-1:0] clamp_int(input logic signed [INT_W-1:0] v,
                                                          input logic signed [1:0] d);
        if ((d == 2'b01) && (v == INT_POS)) begin
            return INT_POS;
        end else if ((d == 2'b11) && (v == INT_NEG)) begin
            return INT_NEG;
        end
        return v + {{(INT_W-2){d[1]}}, d};
    endfunction

    logic signed [INT_W-1:0] r_int;
    logic signed [INT_W-1:0] w_int_new;
    logic signed [INT_W-1:0] w_int_shr;

    assign w_int_new  = clamp_int(r_int, r_dec);
    assign w_int_shr  = w_int_new >>> KI_SHIFT;
    assign w_int_term = {w_int_shr[INT_W-1], w_int_shr};

    // Frequency integrator: advances once per applied decision.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_int <= '0;
        end else if (w_update) begin
            r_int <= w_int_new;
        end
    end

    assign Int_Out = r_int;
    assign Sat     = (r_int == INT_POS) || (r_int == INT_NEG);
`else
    assign w_int_term = '0;
    assign Int_Out    = '0;
    assign Sat        = 1'b0;
`endif

    // Proportional term: decision scaled by KP.
    always_comb begin
        w_prop = '0;
        if (r_dec == 2'b01) begin
            w_prop = KP_STEP;
        end else if (r_dec == 2'b11) begin
            w_prop = -KP_STEP;
        end
    end

    assign w_step      = w_prop + w_int_term;
    // Size cast sign-extends or truncates; only the low CODE_W bits matter for the wrap.
    assign w_step_code = CODE_W'(w_step);

    // Phase code register: modulo-2^CODE_W accumulation plus update strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_code <= CODE_W'(RESET_CODE);
            r_upd  <= 1'b0;
        end else begin
            r_upd <= w_update;
            if (w_update) begin
                r_code <= r_code + w_step_code;
            end
        end
    end

    assign Code        = r_code;
    assign Code_Update = r_upd;

endmodule

// File: tb/tb_cdr_loop_filter.sv
// tb_cdr_loop_filter
// Scoreboard bench for cdr_loop_filter. Two instances share the same stimulus:
// A uses default parameters, B uses RESET_CODE=2046 and INT_W=8. Stimulus
// pushes the expected result of each decision; a monitor pops on Code_Update.
module tb_cdr_loop_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic        up, dn, vv, frz;
    logic [10:0] code_a, code_b;
    logic        upd_a, upd_b;
    logic [15:0] int_a;
    logic [7:0]  int_b;
    logic        sat_a, sat_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int code;
        int intg;
        bit sat;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    int ma_code, ma_int, mb_code, mb_int;
    int prev_a;

`ifdef CDR_INT_PATH_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    cdr_loop_filter u_dut_a (
        .CLK(clk), .RST(rst), .Up(up), .Dn(dn), .Vote_Valid(vv), .Freeze(frz),
        .Code(code_a), .Code_Update(upd_a), .Int_Out(int_a), .Sat(sat_a)
    );

    cdr_loop_filter #(.RESET_CODE(2046), .INT_W(8)) u_dut_b (
        .CLK(clk), .RST(rst), .Up(up), .Dn(dn), .Vote_Valid(vv), .Freeze(frz),
        .Code(code_b), .Code_Update(upd_b), .Int_Out(int_b), .Sat(sat_b)
    );

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endfunction

    // Reference loop: clamped integrator, KP=4, KI_SHIFT=4, 11-bit wrap.
    function automatic exp_t adv(inout int code, inout int intg, input int d, input int maxv);
        exp_t e;
        int   step;
        if (INT_EN) begin
            intg = intg + d;
            if (intg > maxv)  intg = maxv;
            if (intg < -maxv) intg = -maxv;
            step = d * 4 + (intg >>> 4);
        end else begin
            step = d * 4;
        end
        code   = (code + step) & 2047;
        e.code = code;
        e.intg = intg;
        e.sat  = (intg == maxv) || (intg == -maxv);
        return e;
    endfunction

    task automatic push_dec(input int d);
        qa.push_back(adv(ma_code, ma_int, d, 32767));
        qb.push_back(adv(mb_code, mb_int, d, 127));
    endtask

    task automatic model_reset();
        ma_code = 0;
        ma_int  = 0;
        mb_code = 2046;
        mb_int  = 0;
    endtask

    task automatic send(input bit u, input bit d, input bit v, input bit f);
        up  = u;
        dn  = d;
        vv  = v;
        frz = f;
        @(posedge clk);
        #1;
        up  = 1'b0;
        dn  = 1'b0;
        vv  = 1'b0;
        frz = 1'b0;
    endtask

    task automatic up_win();
        repeat (8) send(1, 0, 1, 0);
        push_dec(1);
    endtask

    task automatic dn_win();
        repeat (8) send(0, 1, 1, 0);
        push_dec(-1);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        chk("drain_pending", qa.size() + qb.size(), 0);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        model_reset();
        @(negedge clk);
        chk("rst_code_a", int'(code_a), 0);
        chk("rst_code_b", int'(code_b), 2046);
        chk("rst_int_a", int'($signed(int_a)), 0);
        chk("rst_upd_a", int'(upd_a), 0);
        chk("rst_sat_b", int'(sat_b), 0);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: every Code_Update pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (upd_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL upd_a_unexpected code=%0d expected no pulse", code_a);
            end else begin
                ea = qa.pop_front();
                chk("mon_code_a", int'(code_a), ea.code);
                chk("mon_int_a", int'($signed(int_a)), ea.intg);
                chk("mon_sat_a", int'(sat_a), int'(ea.sat));
            end
        end
        if (upd_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL upd_b_unexpected code=%0d expected no pulse", code_b);
            end else begin
                eb = qb.pop_front();
                chk("mon_code_b", int'(code_b), eb.code);
                chk("mon_int_b", int'($signed(int_b)), eb.intg);
                chk("mon_sat_b", int'(sat_b), int'(eb.sat));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        up  = 1'b0;
        dn  = 1'b0;
        vv  = 1'b0;
        frz = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("init_code_a", int'(code_a), 0);
        chk("init_code_b", int'(code_b), 2046);
        chk("init_int_a", int'($signed(int_a)), 0);
        chk("init_upd_a", int'(upd_a), 0);
        chk("init_sat_a", int'(sat_a), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of a window, then a full fresh window is needed.
        repeat (3) send(1, 0, 1, 0);
        pulse_reset();
        repeat (7) send(1, 0, 1, 0);
        repeat (3) send(1, 0, 0, 0);
        chk("no_early_code_a", int'(code_a), 0);
        send(1, 0, 1, 0);
        push_dec(1);
        drain();
        chk("first_code_a", int'(code_a), 4);
        chk("first_code_b_wrap", int'(code_b), 2);
        chk("first_int_a", int'($signed(int_a)), INT_EN ? 1 : 0);

        // Downward wrap from code 0: step is -4 plus (-1 >>> 4) = -1.
        pulse_reset();
        dn_win();
        drain();
        chk("dn_wrap_code_a", int'(code_a), INT_EN ? 2043 : 2044);
        chk("dn_wrap_int_a", int'($signed(int_a)), INT_EN ? -1 : 0);
        chk("dn_wrap_code_b", int'(code_b), INT_EN ? 2041 : 2042);

        // Frequency tracking: 32 Up decisions, back-to-back windows.
        pulse_reset();
        repeat (31) up_win();
        drain();
        prev_a = int'(code_a);
        up_win();
        drain();
        chk("step32_a", (int'(code_a) - prev_a) & 2047, INT_EN ? 6 : 4);
        chk("int32_a", int'($signed(int_a)), INT_EN ? 32 : 0);
        chk("code32_a", int'(code_a), INT_EN ? 146 : 128);
        chk("code32_b", int'(code_b), INT_EN ? 144 : 126);

        // Null window (3 Up, 3 Dn, 2 Up&Dn) with Vote_Valid gaps: d=0.
        send(1, 0, 1, 0);
        send(1, 0, 0, 0);
        send(1, 0, 1, 0);
        send(1, 1, 1, 0);
        send(0, 0, 0, 0);
        send(0, 1, 1, 0);
        send(1, 0, 1, 0);
        send(1, 1, 1, 0);
        send(0, 1, 1, 0);
        send(0, 1, 1, 0);
        push_dec(0);
        drain();
        chk("null_code_a", int'(code_a), INT_EN ? 148 : 128);
        chk("null_int_a", int'($signed(int_a)), INT_EN ? 32 : 0);

        // Freeze mid-window restarts the window.
        repeat (5) send(1, 0, 1, 0);
        send(1, 0, 1, 1);
        repeat (7) send(1, 0, 1, 0);
        repeat (3) send(0, 0, 0, 0);
        chk("frz_hold_code_a", int'(code_a), INT_EN ? 148 : 128);
        send(1, 0, 1, 0);
        push_dec(1);
        drain();
        chk("frz_code_a", int'(code_a), INT_EN ? 154 : 132);
        chk("frz_int_a", int'($signed(int_a)), INT_EN ? 33 : 0);

        // Freeze in the cycle after a decision discards it.
        repeat (8) send(1, 0, 1, 0);
        send(0, 0, 0, 1);
        repeat (4) send(0, 0, 0, 0);
        chk("frz_discard_code_a", int'(code_a), INT_EN ? 154 : 132);
        chk("frz_discard_int_a", int'($signed(int_a)), INT_EN ? 33 : 0);

        // Saturation of the 8-bit integrator, then release by one Dn decision.
        pulse_reset();
        repeat (130) up_win();
        drain();
        chk("sat_int_b", int'($signed(int_b)), INT_EN ? 127 : 0);
        chk("sat_flag_b", int'(sat_b), INT_EN ? 1 : 0);
        chk("sat_int_a", int'($signed(int_a)), INT_EN ? 130 : 0);
        chk("sat_flag_a", int'(sat_a), 0);
        dn_win();
        drain();
        chk("unsat_int_b", int'($signed(int_b)), INT_EN ? 126 : 0);
        chk("unsat_flag_b", int'(sat_b), 0);
        chk("unsat_int_a", int'($signed(int_a)), INT_EN ? 129 : 0);

        repeat (4) send(0, 0, 0, 0);
        chk("final_queues_empty", qa.size() + qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
